// File: rtl/fwd_hazard_unit.sv
// Decode, ID-stage forwarding and hazard detection for a 5-stage MIPS pipeline.
// Keeps a shadow EX/MEM/WB copy of destination and control state to resolve RAW hazards.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  hold,
  input  logic [5:0]            op,
  input  logic [5:0]            func,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  stall,
  output logic                  illegal,
  output logic [1:0]            d_fwda,
  output logic [1:0]            d_fwdb,
  output logic                  e_wreg,
  output logic                  e_m2reg,
  output logic                  e_wmem,
  output logic                  e_aluimm,
  output logic [3:0]            e_aluc,
  output logic [REG_ADDR_W-1:0] e_dest,
  output logic                  m_wreg,
  output logic                  m_m2reg,
  output logic                  m_wmem,
  output logic [REG_ADDR_W-1:0] m_dest,
  output logic                  w_wreg,
  output logic                  w_m2reg,
  output logic [REG_ADDR_W-1:0] w_dest
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_AND = 6'b100100;

  logic                  d_wreg;
  logic                  d_m2reg;
  logic                  d_wmem;
  logic                  d_aluimm;
  logic [3:0]            d_aluc;
  logic [REG_ADDR_W-1:0] d_dest;
  logic [1:0]            src_used;   // bit 0: rs, bit 1: rt
  logic [1:0]            hazard;
  logic [3:0]            fwd_sel;
  logic                  hazard_any;

  always_comb begin
    d_wreg   = 1'b0;
    d_m2reg  = 1'b0;
    d_wmem   = 1'b0;
    d_aluimm = 1'b0;
    d_aluc   = 4'b0000;
    d_dest   = '0;
    src_used = 2'b00;
    illegal  = 1'b0;
    if (id_valid) begin
      case (op)
        OP_RTYPE: begin
          d_wreg   = 1'b1;
          d_dest   = rd;
          src_used = 2'b11;
          case (func)
            FN_ADD:  d_aluc = 4'b0000;
            FN_SUB:  d_aluc = 4'b0001;
            FN_OR:   d_aluc = 4'b0010;
            FN_XOR:  d_aluc = 4'b0011;
            FN_AND:  d_aluc = 4'b0100;
            default: begin
              // Unknown function code degrades to a NOP with no sources.
              d_wreg   = 1'b0;
              d_dest   = '0;
              src_used = 2'b00;
              illegal  = 1'b1;
            end
          endcase
        end
        OP_LW: begin
          d_wreg   = 1'b1;
          d_m2reg  = 1'b1;
          d_aluimm = 1'b1;
          d_dest   = rt;
          src_used = 2'b01;
        end
        OP_SW: begin
          d_wmem   = 1'b1;
          d_aluimm = 1'b1;
          src_used = 2'b11;
        end
        OP_ADDI: begin
          d_wreg   = 1'b1;
          d_aluimm = 1'b1;
          d_dest   = rt;
          src_used = 2'b01;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [REG_ADDR_W-1:0] src;
    logic                  eligible;
    logic                  ex_match;
    logic                  mem_match;

    assign src       = (gi == 0) ? rs : rt;
    assign eligible  = src_used[gi] && (!ZERO_REG || (src != '0));
    assign ex_match  = eligible && e_wreg && (e_dest == src);
    assign mem_match = eligible && m_wreg && (m_dest == src);

    // A load in EX cannot be forwarded yet; the select falls back to MEM while stalling.
    assign hazard[gi] = FWD_EN ? (ex_match && e_m2reg) : (ex_match || mem_match);
    assign fwd_sel[gi*2 +: 2] = !FWD_EN                 ? 2'b00 :
                                (ex_match && !e_m2reg)  ? 2'b01 :
                                mem_match               ? (m_m2reg ? 2'b11 : 2'b10) :
                                                          2'b00;
  end

  assign hazard_any = |hazard;
  assign stall      = hold || hazard_any;
  assign d_fwda     = fwd_sel[1:0];
  assign d_fwdb     = fwd_sel[3:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_aluc   <= 4'b0000;
      e_dest   <= '0;
      m_wreg   <= 1'b0;
      m_m2reg  <= 1'b0;
      m_wmem   <= 1'b0;
      m_dest   <= '0;
      w_wreg   <= 1'b0;
      w_m2reg  <= 1'b0;
      w_dest   <= '0;
    end else if (!hold) begin
      w_wreg  <= m_wreg;
      w_m2reg <= m_m2reg;
      w_dest  <= m_dest;
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_wmem  <= e_wmem;
      m_dest  <= e_dest;
      if (hazard_any) begin
        e_wreg   <= 1'b0;
        e_m2reg  <= 1'b0;
        e_wmem   <= 1'b0;
        e_aluimm <= 1'b0;
        e_aluc   <= 4'b0000;
        e_dest   <= '0;
      end else begin
        e_wreg   <= d_wreg;
        e_m2reg  <= d_m2reg;
        e_wmem   <= d_wmem;
        e_aluimm <= d_aluimm;
        e_aluc   <= d_aluc;
        e_dest   <= d_dest;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three configurations on shared inputs, directed tables
// plus random stimulus against a stage-list reference model.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic [3:0] aluc;
    logic [4:0] dest;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic use_rs;
    logic use_rt;
    logic ill;
  } dec_t;

  typedef struct packed {
    logic       stall;
    logic       haz;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       hold;
    logic       vld;
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       chk_main;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ill;
    logic       ewreg;
    logic [1:0] fa_z0;
    logic       chk_nf;
    logic       stall_nf;
  } vec_t;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, OR_ = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110, AND_ = 6'b100100;

  logic       clk = 1'b0;
  logic       rst, hold, id_valid;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;

  logic        stall_v [3];
  logic        ill_v   [3];
  logic [1:0]  fa_v    [3];
  logic [1:0]  fb_v    [3];
  logic [27:0] regs_v  [3];

  ctl_t mst [3][3];  // [config][0=EX,1=MEM,2=WB]
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Config 0: forwarding, r0 excluded; 1: forwarding, r0 eligible; 2: no forwarding.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic       stall, illegal, e_wreg, e_m2reg, e_wmem, e_aluimm;
    logic       m_wreg, m_m2reg, m_wmem, w_wreg, w_m2reg;
    logic [1:0] d_fwda, d_fwdb;
    logic [3:0] e_aluc;
    logic [4:0] e_dest, m_dest, w_dest;

    fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(gi != 2), .ZERO_REG(gi != 1)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .hold(hold),
      .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
      .stall(stall), .illegal(illegal), .d_fwda(d_fwda), .d_fwdb(d_fwdb),
      .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_aluimm(e_aluimm),
      .e_aluc(e_aluc), .e_dest(e_dest),
      .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_dest(m_dest),
      .w_wreg(w_wreg), .w_m2reg(w_m2reg), .w_dest(w_dest)
    );

    assign stall_v[gi] = stall;
    assign ill_v[gi]   = illegal;
    assign fa_v[gi]    = d_fwda;
    assign fb_v[gi]    = d_fwdb;
    assign regs_v[gi]  = {e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_dest,
                          m_wreg, m_m2reg, m_wmem, m_dest, w_wreg, w_m2reg, w_dest};
  end

  function automatic dec_t decode();
    dec_t d;
    d = '0;
    if (id_valid) begin
      if (op == R) begin
        d.use_rs = 1'b1; d.use_rt = 1'b1; d.c.wreg = 1'b1; d.c.dest = rd;
        if (func == ADD) d.c.aluc = 4'd0;
        else if (func == SUB) d.c.aluc = 4'd1;
        else if (func == OR_) d.c.aluc = 4'd2;
        else if (func == XOR_) d.c.aluc = 4'd3;
        else if (func == AND_) d.c.aluc = 4'd4;
        else begin d = '0; d.ill = 1'b1; end
      end else if (op == LW) begin
        d.use_rs = 1'b1; d.c.wreg = 1'b1; d.c.m2reg = 1'b1; d.c.aluimm = 1'b1; d.c.dest = rt;
      end else if (op == SW) begin
        d.use_rs = 1'b1; d.use_rt = 1'b1; d.c.wmem = 1'b1; d.c.aluimm = 1'b1;
      end else if (op == ADDI) begin
        d.use_rs = 1'b1; d.c.wreg = 1'b1; d.c.aluimm = 1'b1; d.c.dest = rt;
      end else d.ill = 1'b1;
    end
    return d;
  endfunction

  // Scan the in-flight producers youngest first; the first usable one supplies the operand.
  function automatic exp_t model_comb(int c);
    exp_t       x;
    dec_t       d;
    logic [4:0] src  [2];
    logic       used [2];
    logic [1:0] sel;
    bit         fwd, zr, done;
    x = '0;
    d = decode();
    fwd = (c != 2);
    zr  = (c != 1);
    src[0] = rs;  src[1] = rt;
    used[0] = d.use_rs;  used[1] = d.use_rt;
    for (int s = 0; s < 2; s++) begin
      sel = 2'd0;
      done = 1'b0;
      for (int st = 0; st < 2; st++) begin
        if (!done && used[s] && mst[c][st].wreg && mst[c][st].dest == src[s] &&
            !(zr && src[s] == 5'd0)) begin
          if (!fwd) begin
            x.haz = 1'b1; done = 1'b1;
          end else if (st == 0 && mst[c][st].m2reg) begin
            x.haz = 1'b1;
          end else begin
            sel = (st == 0) ? 2'd1 : (mst[c][st].m2reg ? 2'd3 : 2'd2);
            done = 1'b1;
          end
        end
      end
      if (s == 0) x.fa = sel; else x.fb = sel;
    end
    x.stall = x.haz || hold;
    x.ill = d.ill;
    return x;
  endfunction

  function automatic logic [27:0] pack_regs(int c);
    ctl_t e, m, w;
    e = mst[c][0]; m = mst[c][1]; w = mst[c][2];
    return {e.wreg, e.m2reg, e.wmem, e.aluimm, e.aluc, e.dest,
            m.wreg, m.m2reg, m.wmem, m.dest, w.wreg, w.m2reg, w.dest};
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cfg%0d cyc%0d got=%0h want=%0h", name, c, cyc, got, want);
    end
  endtask

  task automatic model_check();
    exp_t x;
    for (int c = 0; c < 3; c++) begin
      x = model_comb(c);
      chk("stall", c, {31'd0, stall_v[c]}, {31'd0, x.stall});
      chk("fwda", c, {30'd0, fa_v[c]}, {30'd0, x.fa});
      chk("fwdb", c, {30'd0, fb_v[c]}, {30'd0, x.fb});
      chk("illegal", c, {31'd0, ill_v[c]}, {31'd0, x.ill});
      chk("regs", c, {4'd0, regs_v[c]}, {4'd0, pack_regs(c)});
    end
  endtask

  task automatic model_update();
    exp_t x;
    dec_t d;
    d = decode();
    for (int c = 0; c < 3; c++) begin
      x = model_comb(c);
      if (rst) begin
        for (int st = 0; st < 3; st++) mst[c][st] = '0;
      end else if (!hold) begin
        mst[c][2] = mst[c][1];
        mst[c][1] = mst[c][0];
        mst[c][0] = x.haz ? '0 : d.c;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; hold = v.hold; id_valid = v.vld;
    op = v.op; func = v.func; rs = v.rs; rt = v.rt; rd = v.rd;
    #1;
    if (chk_en) model_check();
    if (v.chk_main) begin
      chk("t_stall", 0, {31'd0, stall_v[0]}, {31'd0, v.stall});
      chk("t_fwda", 0, {30'd0, fa_v[0]}, {30'd0, v.fa});
      chk("t_fwdb", 0, {30'd0, fb_v[0]}, {30'd0, v.fb});
      chk("t_illegal", 0, {31'd0, ill_v[0]}, {31'd0, v.ill});
      chk("t_e_wreg", 0, {31'd0, regs_v[0][27]}, {31'd0, v.ewreg});
      chk("t_fwda_z0", 1, {30'd0, fa_v[1]}, {30'd0, v.fa_z0});
    end
    if (v.chk_nf) begin
      chk("t_nf_stall", 2, {31'd0, stall_v[2]}, {31'd0, v.stall_nf});
      chk("t_nf_fwda", 2, {30'd0, fa_v[2]}, 32'd0);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic r, logic h, logic vl, logic [5:0] o, logic [5:0] f,
                              logic [4:0] s, logic [4:0] t, logic [4:0] dd,
                              logic st, logic [1:0] a, logic [1:0] b, logic il,
                              logic ew, logic [1:0] az);
    vec_t v;
    v = '0;
    v.rst = r; v.hold = h; v.vld = vl; v.op = o; v.func = f; v.rs = s; v.rt = t; v.rd = dd;
    v.chk_main = 1'b1; v.stall = st; v.fa = a; v.fb = b; v.ill = il; v.ewreg = ew; v.fa_z0 = az;
    return v;
  endfunction

  function automatic vec_t mknf(logic vl, logic [5:0] f, logic [4:0] s, logic [4:0] t,
                                logic [4:0] dd, logic st);
    vec_t v;
    v = '0;
    v.vld = vl; v.op = R; v.func = f; v.rs = s; v.rt = t; v.rd = dd;
    v.chk_nf = 1'b1; v.stall_nf = st;
    return v;
  endfunction

  vec_t       tbl [$];
  vec_t       rv;
  logic [5:0] funcs [5];
  int         k;

  initial begin
    rst = 1'b1; hold = 1'b0; id_valid = 1'b0;
    op = '0; func = '0; rs = '0; rt = '0; rd = '0;
    funcs[0] = ADD; funcs[1] = SUB; funcs[2] = OR_; funcs[3] = XOR_; funcs[4] = AND_;
    for (int c = 0; c < 3; c++) for (int st = 0; st < 3; st++) mst[c][st] = '0;

    //             rst hold vld op    func  rs  rt  rd  stall fa  fb  ill ewreg faz0
    tbl.push_back(mk(0, 0, 1, R,     ADD,  1,  2,  3,  0,  0,  0,  0,  0,  0)); // add r3,r1,r2
    tbl.push_back(mk(0, 0, 1, R,     SUB,  3,  1,  4,  0,  1,  0,  0,  1,  1)); // sub r4,r3,r1
    tbl.push_back(mk(0, 0, 1, R,     OR_,  3,  0,  5,  0,  2,  0,  0,  1,  2)); // or r5,r3,r0
    tbl.push_back(mk(0, 0, 1, LW,    6'd0, 1,  2,  0,  0,  0,  0,  0,  1,  0)); // lw r2,0(r1)
    tbl.push_back(mk(0, 0, 1, R,     ADD,  2,  2,  3,  1,  0,  0,  0,  1,  0)); // add r3,r2,r2 load-use
    tbl.push_back(mk(0, 0, 1, R,     ADD,  2,  2,  3,  0,  3,  3,  0,  0,  3)); // bubble in EX
    tbl.push_back(mk(0, 0, 1, R,     ADD,  1,  1,  0,  0,  0,  0,  0,  1,  0)); // add r0,r1,r1
    tbl.push_back(mk(0, 0, 1, R,     ADD,  0,  0,  2,  0,  0,  0,  0,  1,  1)); // add r2,r0,r0
    tbl.push_back(mk(0, 1, 1, R,     OR_,  1,  1,  6,  1,  0,  0,  0,  1,  0)); // hold x3
    tbl.push_back(mk(0, 1, 1, R,     OR_,  1,  1,  6,  1,  0,  0,  0,  1,  0));
    tbl.push_back(mk(0, 1, 1, R,     OR_,  1,  1,  6,  1,  0,  0,  0,  1,  0));
    tbl.push_back(mk(0, 0, 1, R,     OR_,  1,  1,  6,  0,  0,  0,  0,  1,  0));
    tbl.push_back(mk(0, 0, 1, 6'h3f, 6'd0, 0,  0,  0,  0,  0,  0,  1,  1,  0)); // illegal op
    tbl.push_back(mk(0, 0, 0, R,     6'd0, 0,  0,  0,  0,  0,  0,  0,  0,  0)); // idle
    tbl.push_back(mk(0, 0, 1, LW,    6'd0, 1,  7,  0,  0,  0,  0,  0,  0,  0)); // lw r7,0(r1)
    tbl.push_back(mk(1, 0, 1, R,     ADD,  7,  0,  8,  1,  0,  0,  0,  1,  0)); // rst while stalled
    tbl.push_back(mk(0, 0, 0, R,     6'd0, 0,  0,  0,  0,  0,  0,  0,  0,  0)); // pipeline empty
    // No-forwarding build: add r3 then and r4,r3,r3 waits out EX and MEM.
    tbl.push_back(mknf(1, ADD,  1, 2, 3, 0));
    tbl.push_back(mknf(1, AND_, 3, 3, 4, 1));
    tbl.push_back(mknf(1, AND_, 3, 3, 4, 1));
    tbl.push_back(mknf(1, AND_, 3, 3, 4, 0));
    tbl.push_back(mknf(0, ADD,  0, 0, 0, 0));

    @(negedge clk);
    rv = '0;
    rv.rst = 1'b1;
    apply(rv);
    chk_en = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    for (int n = 0; n < 3000; n++) begin
      rv = '0;
      rv.rst  = ($urandom_range(0, 99) < 2);
      rv.hold = ($urandom_range(0, 99) < 10);
      rv.vld  = ($urandom_range(0, 99) < 90);
      k = $urandom_range(0, 9);
      rv.op = R;
      rv.func = funcs[$urandom_range(0, 4)];
      if (k == 5) rv.op = LW;
      else if (k == 6) rv.op = SW;
      else if (k == 7) rv.op = ADDI;
      else if (k == 8) rv.func = 6'($urandom);
      else if (k == 9) rv.op = 6'($urandom);
      rv.rs = 5'($urandom_range(0, 3));
      rv.rt = 5'($urandom_range(0, 3));
      rv.rd = 5'($urandom_range(0, 3));
      apply(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised decode, forwarding and hazard unit for the 5-stage MIPS pipeline; successor to the purely combinational control/forwarding decoder. It decodes the ID-stage instruction, keeps its own shadow pipeline of destination/control state for EX, MEM and WB, and computes ID-stage forwarding selects with EX-over-MEM priority and register-0 exclusion. It also detects load-use and RAW hazards, stalling IF/ID and injecting bubbles into EX. A no-forwarding mode is provided for debug.

## Interface
- REG_ADDR_W, 5, register-address width
- FWD_EN, 1, 1 = forwarding; 0 = stall on every RAW hazard
- ZERO_REG, 1, 1 = register 0 is never a hazard or forward source
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- hold  in  1  external freeze (e.g. memory wait)
- op, func  in  6 each  instruction fields
- rs, rt, rd  in  REG_ADDR_W each  register fields
- stall  out  1  freeze PC and IF/ID this cycle (comb)
- illegal  out  1  unknown opcode/func while id_valid (comb)
- d_fwda, d_fwdb  out  2 each  ID operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data (comb)
- e_wreg, e_m2reg, e_wmem, e_aluimm  out  1 each  EX control (reg)
- e_aluc  out  4  EX ALU op (reg)
- e_dest  out  REG_ADDR_W  EX destination (reg)
- m_wreg, m_m2reg, m_wmem  out  1 each  MEM control (reg)
- m_dest  out  REG_ADDR_W
- w_wreg, w_m2reg  out  1 each; w_dest  out  REG_ADDR_W  WB (reg)

## Operation
- Decode (func for op=000000): add 100000 aluc 0000; sub 100010 0001; or 100101 0010; xor 100110 0011; and 100100 0100 — wreg=1, dest=rd, sources rs,rt.
- lw 100011: wreg, m2reg, aluimm, aluc 0000, dest=rt, source rs. sw 101011: wmem, aluimm, aluc 0000, sources rs,rt. addi 001000: wreg, aluimm, aluc 0000, dest=rt, source rs.
- Other encodings: illegal=1, all write enables 0 (NOP). id_valid=0: NOP, illegal=0.
- Source match vs stage X: source used, X_wreg=1, X_dest==src, and (ZERO_REG=0 or src!=0).
- FWD_EN=1: EX match with e_m2reg=0 → 01; else MEM match → 10 (m_m2reg=0) or 11 (m_m2reg=1); else 00. EX beats MEM. EX match with e_m2reg=1 → load-use, stall=1.
- FWD_EN=0: any EX or MEM match → stall=1; d_fwda/d_fwdb always 00. WB never hazards (regfile write-before-read).
- stall also 1 whenever hold=1. Selects remain valid during stall.

## Timing
- Reset: every registered output 0 (e_*, m_*, w_*); comb outputs follow from zeroed state.
- Per edge, hold=0: W<=M, M<=E; E<=decode if stall=0, else bubble (all E fields 0).
- hold=1: E, M, W keep values; takes precedence over bubble.
- Load-use: exactly 1 stall cycle (FWD_EN=1); then MEM match gives 11.
- FWD_EN=0: dependent on EX producer stalls 2 cycles, on MEM producer 1.
- rst mid-stall: next cycle all stages empty, stall=0.
- Latency decode→e_* is 1 cycle; e_*→m_* 1; m_*→w_* 1.

## Test plan
- rst with full pipeline → all e_/m_/w_ 0 next cycle, stall=0.
- add r3,r1,r2 then sub r4,r3,r1 → d_fwda=01, no stall; third instr or r5,r3,r0 → d_fwda=10.
- lw r2,0(r1) then add r3,r2,r2 → stall=1 one cycle, e_wreg=0 bubble, then d_fwda=d_fwdb=11.
- add r0,r1,r1 then add r2,r0,r0 with ZERO_REG=1 → fwd 00, no stall; ZERO_REG=0 → 01.
- FWD_EN=0, add r3,.. then and r4,r3,r3 → stall 2 cycles, selects 00, then proceeds.
- hold=1 for 3 cycles mid-sequence → e_/m_/w_ frozen, stall=1; op=111111 → illegal=1, e_wreg=e_wmem=0.
